// File: rtl/rs_issue_sched_pkg.sv
// rs_issue_sched_pkg: shared RS slot constants, types and a one-hot to index helper.
package rs_issue_sched_pkg;
  localparam int RsLength = 7;
  localparam int IdxWidth = 3;
  localparam int RsSlots = RsLength + 1;
  typedef logic [RsSlots-1:0] slot_vec_t;
  typedef logic [IdxWidth-1:0] slot_idx_t;
  typedef logic [IdxWidth:0] slot_cnt_t;
  function automatic slot_idx_t onehot_to_idx(input slot_vec_t oh);
    onehot_to_idx = '0;
    for (int i = 0; i < RsSlots; i++)
      if (oh[i]) onehot_to_idx = onehot_to_idx | slot_idx_t'(i);
  endfunction
endpackage

// File: rtl/rs_issue_sched_age_matrix.sv
// rs_age_matrix: N x N age bits with alloc/clear update and oldest-eligible select.
module rs_age_matrix
  import rs_issue_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      alloc_valid,
  input  slot_idx_t alloc_idx,
  input  slot_vec_t eligible,
  output slot_vec_t grant_oh,
  output slot_idx_t grant_idx
);
  logic [RsSlots-1:0][RsSlots-1:0] older;
  always_ff @(posedge clk or negedge rst)
    if (!rst) older <= '0;
    else if (clear) older <= '0;
    else if (alloc_valid)
      for (int i = 0; i < RsSlots; i++)
        if (i == int'(alloc_idx)) older[i] <= '0;
        else older[i][alloc_idx] <= 1'b1;
  // A slot wins only if no other eligible slot is older than it.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < RsSlots; i++) begin
      grant_oh[i] = eligible[i];
      for (int j = 0; j < RsSlots; j++)
        grant_oh[i] = grant_oh[i] & ~(eligible[j] & older[j][i]);
    end
  end
  assign grant_idx = onehot_to_idx(grant_oh);
endmodule

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: oldest-ready RS issue scheduler with registered valid/ready grant to the ALU.
// Optional perf counters when RS_SCHED_PERF_EN is defined.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                is_flush_in,
  input  logic                alloc_valid_in,
  input  logic [IdxWidth-1:0] alloc_idx_in,
  input  logic [RsSlots-1:0]  ready_vec_in,
  output logic                issue_valid_out,
  output logic [IdxWidth-1:0] issue_idx_out,
  input  logic                issue_ready_in,
  output logic                free_valid_out,
  output logic [IdxWidth:0]   busy_count_out,
`ifdef RS_SCHED_PERF_EN
  output logic [31:0]         perf_issue_cnt_out,
  output logic [31:0]         perf_stall_cnt_out,
`endif
  output logic                is_full_out
);
  logic fire, take;
  slot_vec_t valid_vec, held, eligible, grant_oh;
  slot_idx_t grant_idx;
  slot_cnt_t count_next;
  assign fire = issue_valid_out & issue_ready_in;
  assign free_valid_out = fire & ~is_flush_in;
  assign take = ~issue_valid_out | fire;
  // The slot sitting in the output register is never reselected, firing or not.
  assign held = issue_valid_out ? slot_vec_t'(1) << issue_idx_out : '0;
  assign eligible = valid_vec & ready_vec_in & ~held;
  assign count_next = busy_count_out + slot_cnt_t'(alloc_valid_in) - slot_cnt_t'(fire);
  rs_age_matrix u_age (
    .clk(clk),
    .rst(rst),
    .clear(is_flush_in),
    .alloc_valid(alloc_valid_in),
    .alloc_idx(alloc_idx_in),
    .eligible(eligible),
    .grant_oh(grant_oh),
    .grant_idx(grant_idx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_vec <= '0;
      issue_valid_out <= 1'b0;
      issue_idx_out <= '0;
      busy_count_out <= '0;
      is_full_out <= 1'b0;
    end else if (is_flush_in) begin
      valid_vec <= '0;
      issue_valid_out <= 1'b0;
      busy_count_out <= '0;
      is_full_out <= 1'b0;
    end else begin
      valid_vec <= (valid_vec & ~(fire ? held : '0)) | (alloc_valid_in ? slot_vec_t'(1) << alloc_idx_in : '0);
      busy_count_out <= count_next;
      is_full_out <= count_next == slot_cnt_t'(RsSlots);
      if (take) begin
        issue_valid_out <= |grant_oh;
        issue_idx_out <= grant_idx;
      end
    end
`ifdef RS_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_issue_cnt_out <= '0;
      perf_stall_cnt_out <= '0;
    end else begin
      if (free_valid_out) perf_issue_cnt_out <= perf_issue_cnt_out + 32'd1;
      if (issue_valid_out && !issue_ready_in) perf_stall_cnt_out <= perf_stall_cnt_out + 32'd1;
    end
`endif
  // Overwriting a live slot is only legal when that slot is leaving this cycle.
  alloc_legal: assert property (@(posedge clk) disable iff (!rst)
    alloc_valid_in && !is_flush_in |-> !valid_vec[alloc_idx_in] || (fire && issue_idx_out == alloc_idx_in));
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: table-driven directed checks plus hand sequences for reset and perf counters.
module tb_rs_issue_sched;
  logic clk = 1'b0, rst = 1'b0;
  logic is_flush_in = 0, alloc_valid_in = 0, issue_ready_in = 0;
  logic [2:0] alloc_idx_in = 0;
  logic [7:0] ready_vec_in = 0;
  logic issue_valid_out, free_valid_out, is_full_out;
  logic [2:0] issue_idx_out;
  logic [3:0] busy_count_out;
`ifdef RS_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt_out, perf_stall_cnt_out;
`endif
  int checks = 0, errors = 0;

  rs_issue_sched dut (
    .clk(clk),
    .rst(rst),
    .is_flush_in(is_flush_in),
    .alloc_valid_in(alloc_valid_in),
    .alloc_idx_in(alloc_idx_in),
    .ready_vec_in(ready_vec_in),
    .issue_valid_out(issue_valid_out),
    .issue_idx_out(issue_idx_out),
    .issue_ready_in(issue_ready_in),
    .free_valid_out(free_valid_out),
    .busy_count_out(busy_count_out),
`ifdef RS_SCHED_PERF_EN
    .perf_issue_cnt_out(perf_issue_cnt_out),
    .perf_stall_cnt_out(perf_stall_cnt_out),
`endif
    .is_full_out(is_full_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [2:0] ai; logic [7:0] rv; logic ir; logic fl;
    logic ev; logic [2:0] ei; logic [3:0] ec; logic ef; logic efr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic av, input logic [2:0] ai, input logic [7:0] rv, input logic ir, input logic fl,
                     input logic ev, input logic [2:0] ei, input logic [3:0] ec, input logic ef, input logic efr);
    tbl.push_back('{av, ai, rv, ir, fl, ev, ei, ec, ef, efr});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic av, input logic [2:0] ai, input logic [7:0] rv, input logic ir, input logic fl);
    @(negedge clk);
    alloc_valid_in = av; alloc_idx_in = ai; ready_vec_in = rv; issue_ready_in = ir; is_flush_in = fl;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [2:0] ei, input logic [3:0] ec,
                            input logic ef, input logic efr);
    chk({tag, " valid"}, 32'(issue_valid_out), 32'(ev));
    if (ev) chk({tag, " idx"}, 32'(issue_idx_out), 32'(ei));
    chk({tag, " count"}, 32'(busy_count_out), 32'(ec));
    chk({tag, " full"}, 32'(is_full_out), 32'(ef));
    chk({tag, " free"}, 32'(free_valid_out), 32'(efr));
  endtask

  initial begin
    // Grants 3,1,5 in allocation order once all become ready
    add(1,3,8'h00,1,0, 0,0,0,0,0);
    add(1,1,8'h00,1,0, 0,0,1,0,0);
    add(1,5,8'h00,1,0, 0,0,2,0,0);
    add(0,0,8'hFF,1,0, 0,0,3,0,0);
    add(0,0,8'hFF,1,0, 1,3,3,0,1);
    add(0,0,8'hFF,1,0, 1,1,2,0,1);
    add(0,0,8'hFF,1,0, 1,5,1,0,1);
    add(0,0,8'hFF,1,0, 0,0,0,0,0);
    // Fill all eight slots, then fire one
    for (int i = 0; i < 8; i++) add(1,3'(i),8'h00,0,0, 0,0,4'(i),0,0);
    add(0,0,8'h01,0,0, 0,0,8,1,0);
    add(0,0,8'h01,1,0, 1,0,8,1,1);
    add(0,0,8'h00,0,0, 0,0,7,0,0);
    add(0,0,8'h00,0,1, 0,0,7,0,0);
    // Grant to slot 2 holds while older slot 0 becomes ready
    add(1,0,8'h00,0,0, 0,0,0,0,0);
    add(1,2,8'h00,0,0, 0,0,1,0,0);
    add(0,0,8'h04,0,0, 0,0,2,0,0);
    for (int i = 0; i < 4; i++) add(0,0,8'h05,0,0, 1,2,2,0,0);
    add(0,0,8'h05,1,0, 1,2,2,0,1);
    add(0,0,8'h01,0,0, 1,0,1,0,0);
    add(0,0,8'h01,1,0, 1,0,1,0,1);
    // Fire and realloc slot 4 together; slot 6 now older
    add(1,4,8'h10,0,0, 0,0,0,0,0);
    add(0,0,8'h10,0,0, 0,0,1,0,0);
    add(1,6,8'h50,0,0, 1,4,1,0,0);
    add(1,4,8'h50,1,0, 1,4,2,0,1);
    add(0,0,8'h50,1,0, 1,6,2,0,1);
    add(0,0,8'h50,1,0, 1,4,1,0,1);
    // Flush with a pending grant and five busy slots
    for (int i = 0; i < 5; i++) add(1,3'(i),8'h00,0,0, 0,0,4'(i),0,0);
    add(0,0,8'h01,0,0, 0,0,5,0,0);
    add(0,0,8'h01,1,1, 1,0,5,0,0);
    add(0,0,8'hFF,1,0, 0,0,0,0,0);

    #1;
    expect_out("reset", 0, 0, 0, 0, 0);
    chk("reset idx", 32'(issue_idx_out), 0);
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].av, tbl[i].ai, tbl[i].rv, tbl[i].ir, tbl[i].fl);
      expect_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].ec, tbl[i].ef, tbl[i].efr);
    end

    // Async reset while a grant is being accepted
    cyc(1,1,8'h02,0,0);
    expect_out("ar0", 0, 0, 0, 0, 0);
    cyc(0,0,8'h02,0,0);
    expect_out("ar1", 0, 0, 1, 0, 0);
    cyc(0,0,8'h02,1,0);
    expect_out("ar2", 1, 1, 1, 0, 1);
    #2 rst = 1'b0;
    #1 expect_out("ar_async", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    alloc_valid_in = 0; ready_vec_in = 0; issue_ready_in = 0;

    // Two stall cycles then three fires, then flush
    cyc(1,1,8'h00,0,0);
    cyc(1,2,8'h00,0,0);
    cyc(1,3,8'h00,0,0);
    cyc(0,0,8'h0E,0,0);
    expect_out("pf0", 0, 0, 3, 0, 0);
    cyc(0,0,8'h0E,0,0);
    expect_out("pf1", 1, 1, 3, 0, 0);
    cyc(0,0,8'h0E,0,0);
    expect_out("pf2", 1, 1, 3, 0, 0);
    cyc(0,0,8'h0E,1,0);
    expect_out("pf3", 1, 1, 3, 0, 1);
    cyc(0,0,8'h0E,1,0);
    expect_out("pf4", 1, 2, 2, 0, 1);
    cyc(0,0,8'h0E,1,0);
    expect_out("pf5", 1, 3, 1, 0, 1);
    cyc(0,0,8'h00,0,1);
    expect_out("pf6", 0, 0, 0, 0, 0);
    cyc(0,0,8'h00,0,0);
    expect_out("pf7", 0, 0, 0, 0, 0);
`ifdef RS_SCHED_PERF_EN
    chk("perf issue", perf_issue_cnt_out, 3);
    chk("perf stall", perf_stall_cnt_out, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
